// File: rtl/img_pixel_sram.sv
// -----------------------------------------------------------------------------
// img_pixel_sram
// Frame buffer that captures one image in raster order and serves random-access
// reads with a one-cycle registered latency.
//
// A start_load pulse samples the frame size and opens a LOAD window. Pixels are
// accepted on wr_valid && wr_ready and written in raster order. Accepting the
// last pixel raises frame_ready, and reads then return stored data. A new
// start_load (even mid-load) restarts the load. Reads issued while the frame is
// incomplete return 0.
//
// Build option (macro IMG_SRAM_ZERO_PAD_EN):
//   defined   - reads outside the latched frame return 0 (zero padding)
//   undefined - out-of-frame coordinates clamp to the last column/row
//               (edge replication)
//
// Ports:
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   start_load  in   one-cycle pulse, begins a frame load
//   img_width   in   frame width, sampled on start_load
//   img_height  in   frame height, sampled on start_load
//   wr_valid    in   write pixel present
//   wr_data     in   write pixel, raster order
//   wr_ready    out  pixel accepted this cycle when high together with wr_valid
//   ren_img     in   read enable
//   x_addr_img  in   read column
//   y_addr_img  in   read row
//   rdat_img    out  registered read data
//   frame_ready out  full frame stored, reads valid
//   load_busy   out  frame load in progress
// -----------------------------------------------------------------------------
module img_pixel_sram #(
    parameter int X_MAX       = 60,
    parameter int Y_MAX       = 60,
    parameter int PIXEL_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start_load,
    input  logic [$clog2(X_MAX):0]   img_width,
    input  logic [$clog2(Y_MAX):0]   img_height,
    input  logic                     wr_valid,
    input  logic [PIXEL_DEPTH-1:0]   wr_data,
    output logic                     wr_ready,
    input  logic                     ren_img,
    input  logic [$clog2(X_MAX):0]   x_addr_img,
    input  logic [$clog2(Y_MAX):0]   y_addr_img,
    output logic [PIXEL_DEPTH-1:0]   rdat_img,
    output logic                     frame_ready,
    output logic                     load_busy
);

    localparam int XW    = $clog2(X_MAX) + 1;
    localparam int YW    = $clog2(Y_MAX) + 1;
    localparam int DEPTH = X_MAX * Y_MAX;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    // Zero is promoted to 1 and oversize widths saturate at X_MAX.
    function automatic logic [XW-1:0] clamp_w(input logic [XW-1:0] v);
        logic [XW-1:0] r;
        if (v == {XW{1'b0}}) begin
            r = XW'(1);
        end else if (v > XW'(X_MAX)) begin
            r = XW'(X_MAX);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Zero is promoted to 1 and oversize heights saturate at Y_MAX.
    function automatic logic [YW-1:0] clamp_h(input logic [YW-1:0] v);
        logic [YW-1:0] r;
        if (v == {YW{1'b0}}) begin
            r = YW'(1);
        end else if (v > YW'(Y_MAX)) begin
            r = YW'(Y_MAX);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // The array is laid out with a fixed X_MAX pitch so the address does not
    // depend on the latched width.
    function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
        return AW'(32'(y) * 32'(X_MAX) + 32'(x));
    endfunction

    state_e                 state_q,       state_d;
    logic [XW-1:0]          wr_x_q,        wr_x_d;
    logic [YW-1:0]          wr_y_q,        wr_y_d;
    logic [XW-1:0]          width_q,       width_d;
    logic [YW-1:0]          height_q,      height_d;
    logic                   frame_ready_q, frame_ready_d;
    logic [PIXEL_DEPTH-1:0] rdat_q,        rdat_d;

    logic [PIXEL_DEPTH-1:0] mem_q [DEPTH];

    logic                   wr_ready_s;
    logic                   wr_accept_s;
    logic                   wr_last_s;
    logic [AW-1:0]          wr_idx_s;
    logic [XW-1:0]          rd_x_s;
    logic [YW-1:0]          rd_y_s;
    logic [AW-1:0]          rd_idx_s;
    logic                   rd_zero_s;

    // A start_load pulse blocks acceptance so a restart never races a write.
    always_comb begin
        wr_ready_s  = (state_q == ST_LOAD) && !start_load;
        wr_accept_s = wr_valid && wr_ready_s;
        wr_last_s   = (wr_x_q == (width_q - XW'(1))) &&
                      (wr_y_q == (height_q - YW'(1)));
        wr_idx_s    = addr_of(wr_x_q, wr_y_q);
    end

    // Next-state logic for the load FSM, write counters and latched geometry.
    always_comb begin
        state_d       = state_q;
        wr_x_d        = wr_x_q;
        wr_y_d        = wr_y_q;
        width_d       = width_q;
        height_d      = height_q;
        frame_ready_d = frame_ready_q;
        if (start_load) begin
            state_d       = ST_LOAD;
            wr_x_d        = {XW{1'b0}};
            wr_y_d        = {YW{1'b0}};
            width_d       = clamp_w(img_width);
            height_d      = clamp_h(img_height);
            frame_ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (wr_accept_s && wr_last_s) begin
                        state_d       = ST_READY;
                        wr_x_d        = {XW{1'b0}};
                        wr_y_d        = {YW{1'b0}};
                        frame_ready_d = 1'b1;
                    end else if (wr_accept_s && (wr_x_q == (width_q - XW'(1)))) begin
                        wr_x_d = {XW{1'b0}};
                        wr_y_d = wr_y_q + YW'(1);
                    end else if (wr_accept_s) begin
                        wr_x_d = wr_x_q + XW'(1);
                    end else begin
                        wr_x_d = wr_x_q;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_READY: begin
                    state_d = ST_READY;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control state register; reset abandons any partial frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            wr_x_q        <= {XW{1'b0}};
            wr_y_q        <= {YW{1'b0}};
            width_q       <= XW'(1);
            height_q      <= YW'(1);
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_x_q        <= wr_x_d;
            wr_y_q        <= wr_y_d;
            width_q       <= width_d;
            height_q      <= height_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    // Pixel storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_q[wr_idx_s] <= wr_data;
        end
    end

    // Read address: coordinates are always clamped into the frame so the
    // array index stays in range; zero padding only masks the returned data.
    always_comb begin
        if (x_addr_img >= width_q) begin
            rd_x_s = width_q - XW'(1);
        end else begin
            rd_x_s = x_addr_img;
        end
        if (y_addr_img >= height_q) begin
            rd_y_s = height_q - YW'(1);
        end else begin
            rd_y_s = y_addr_img;
        end
        rd_idx_s = addr_of(rd_x_s, rd_y_s);
`ifdef IMG_SRAM_ZERO_PAD_EN
        rd_zero_s = !frame_ready_q || (x_addr_img >= width_q) ||
                    (y_addr_img >= height_q);
`else
        rd_zero_s = !frame_ready_q;
`endif
        // The array read sees the pre-edge contents, giving read-before-write.
        if (rd_zero_s) begin
            rdat_d = {PIXEL_DEPTH{1'b0}};
        end else begin
            rdat_d = mem_q[rd_idx_s];
        end
    end

    // Registered read data; holds its value when no read is issued.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdat_q <= {PIXEL_DEPTH{1'b0}};
        end else if (ren_img) begin
            rdat_q <= rdat_d;
        end else begin
            rdat_q <= rdat_q;
        end
    end

    assign wr_ready    = wr_ready_s;
    assign rdat_img    = rdat_q;
    assign frame_ready = frame_ready_q;
    assign load_busy   = (state_q == ST_LOAD);

endmodule

// File: tb/tb_img_pixel_sram.sv
// -----------------------------------------------------------------------------
// tb_img_pixel_sram
// Self-checking bench for img_pixel_sram (default geometry 60x60, 8-bit pixels).
// A behavioural frame model (pixel count, latched size, flat pixel array) runs
// alongside the design; directed scenarios are mixed with randomized loads and
// reads. Honours IMG_SRAM_ZERO_PAD_EN for out-of-frame read expectations.
// -----------------------------------------------------------------------------
module tb_img_pixel_sram;

    localparam int XM = 60;
    localparam int YM = 60;

    logic       clk;
    logic       n_rst;
    logic       start_load;
    logic [6:0] img_width;
    logic [6:0] img_height;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       ren_img;
    logic [6:0] x_addr_img;
    logic [6:0] y_addr_img;
    logic [7:0] rdat_img;
    logic       frame_ready;
    logic       load_busy;

    img_pixel_sram #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(8)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start_load  (start_load),
        .img_width   (img_width),
        .img_height  (img_height),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .ren_img     (ren_img),
        .x_addr_img  (x_addr_img),
        .y_addr_img  (y_addr_img),
        .rdat_img    (rdat_img),
        .frame_ready (frame_ready),
        .load_busy   (load_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_mem [XM*YM];
    logic       m_load;
    logic       m_ready;
    logic [7:0] m_rdat;
    int         m_w;
    int         m_h;
    int         m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int mx);
        if (v == 0) return 1;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic logic [7:0] model_read(input int x, input int y);
        int cx;
        int cy;
        if (!m_ready) return 8'h00;
`ifdef IMG_SRAM_ZERO_PAD_EN
        if (x >= m_w || y >= m_h) return 8'h00;
`endif
        cx = (x >= m_w) ? m_w - 1 : x;
        cy = (y >= m_h) ? m_h - 1 : y;
        return m_mem[cy*XM + cx];
    endfunction

    // One clock: predict the edge from current inputs, then compare outputs.
    task automatic step();
        logic acc;
        #2;
        check_eq("wr_ready", 32'(wr_ready), 32'(m_load && !start_load));
        acc = wr_valid && m_load && !start_load;
        if (ren_img) m_rdat = model_read(int'(x_addr_img), int'(y_addr_img));
        if (start_load) begin
            m_load  = 1'b1;
            m_ready = 1'b0;
            m_cnt   = 0;
            m_w     = clampv(int'(img_width), XM);
            m_h     = clampv(int'(img_height), YM);
        end else if (acc) begin
            m_mem[(m_cnt / m_w)*XM + (m_cnt % m_w)] = wr_data;
            m_cnt++;
            if (m_cnt == m_w*m_h) begin
                m_load  = 1'b0;
                m_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("rdat_img", 32'(rdat_img), 32'(m_rdat));
        check_eq("frame_ready", 32'(frame_ready), 32'(m_ready));
        check_eq("load_busy", 32'(load_busy), 32'(m_load));
    endtask

    task automatic do_start(input int w, input int h);
        start_load = 1'b1;
        img_width  = 7'(w);
        img_height = 7'(h);
        step();
        start_load = 1'b0;
    endtask

    task automatic do_read(input int x, input int y);
        ren_img    = 1'b1;
        x_addr_img = 7'(x);
        y_addr_img = 7'(y);
        step();
        ren_img    = 1'b0;
    endtask

    // Assert reset between edges and check the asynchronous clear.
    task automatic do_reset(input string tag);
        #2;
        n_rst = 1'b0;
        #1;
        m_load = 1'b0; m_ready = 1'b0; m_rdat = 8'h00; m_cnt = 0; m_w = 1; m_h = 1;
        check_eq({tag, "_rdat"}, 32'(rdat_img), 32'd0);
        check_eq({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        check_eq({tag, "_load_busy"}, 32'(load_busy), 32'd0);
        check_eq({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        start_load = 1'b0; wr_valid = 1'b0; ren_img = 1'b0;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0; start_load = 1'b0; img_width = 7'd0; img_height = 7'd0;
        wr_valid = 1'b0; wr_data = 8'd0; ren_img = 1'b0;
        x_addr_img = 7'd0; y_addr_img = 7'd0;
        m_load = 1'b0; m_ready = 1'b0; m_rdat = 8'h00; m_w = 1; m_h = 1; m_cnt = 0;

        // Reset state
        #3;
        check_eq("rst_rdat", 32'(rdat_img), 32'd0);
        check_eq("rst_frame_ready", 32'(frame_ready), 32'd0);
        check_eq("rst_load_busy", 32'(load_busy), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        step();

        // 4x3 frame, pixels 0..11 with wr_valid held
        do_start(4, 3);
        for (int i = 0; i < 12; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            step();
            if (i == 10) check_eq("fr_before_last", 32'(frame_ready), 32'd0);
        end
        wr_valid = 1'b0;
        check_eq("fr_after_last", 32'(frame_ready), 32'd1);
        do_read(2, 1);
        check_eq("rd_2_1", 32'(rdat_img), 32'd6);

        // Back-to-back reads, then hold
        ren_img = 1'b1; x_addr_img = 7'd0; y_addr_img = 7'd0; step();
        check_eq("b2b_0_0", 32'(rdat_img), 32'd0);
        x_addr_img = 7'd3; y_addr_img = 7'd2; step();
        check_eq("b2b_3_2", 32'(rdat_img), 32'd11);
        x_addr_img = 7'd1; y_addr_img = 7'd0; step();
        check_eq("b2b_1_0", 32'(rdat_img), 32'd1);
        ren_img = 1'b0; x_addr_img = 7'd3; y_addr_img = 7'd2; step(); step();
        check_eq("hold", 32'(rdat_img), 32'd1);

        // Out-of-range read
        do_read(5, 1);
`ifdef IMG_SRAM_ZERO_PAD_EN
        check_eq("oor_5_1", 32'(rdat_img), 32'd0);
`else
        check_eq("oor_5_1", 32'(rdat_img), 32'd7);
`endif

        // Random reads on the 4x3 frame
        for (int i = 0; i < 40; i++) begin
            ren_img    = 1'($urandom_range(0, 3) != 0);
            x_addr_img = (i % 8 == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
            y_addr_img = (i % 8 == 4) ? 7'($urandom) : 7'($urandom_range(0, 5));
            step();
        end
        ren_img = 1'b0;

        // Restart after 5 accepted pixels
        do_start(4, 3);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 8'($urandom); step();
        end
        wr_data = 8'h55;
        do_start(4, 3);
        wr_data = 8'hAA; step();
        for (int i = 1; i < 12; i++) begin
            wr_data = 8'($urandom); step();
            if (i == 10) check_eq("restart_fr_early", 32'(frame_ready), 32'd0);
        end
        wr_valid = 1'b0;
        check_eq("restart_fr_done", 32'(frame_ready), 32'd1);
        do_read(0, 0);
        check_eq("restart_0_0", 32'(rdat_img), 32'd170);

        // Reset mid-read, then mid-load
        ren_img = 1'b1; x_addr_img = 7'd1; y_addr_img = 7'd0;
        do_reset("rst_read");
        do_read(0, 0);
        check_eq("post_rst_read", 32'(rdat_img), 32'd0);
        do_start(4, 3);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 8'($urandom); step();
        end
        do_reset("rst_load");
        wr_valid = 1'b1; wr_data = 8'h33;
        for (int i = 0; i < 4; i++) step();
        wr_valid = 1'b0;
        do_read(0, 0);
        check_eq("post_rst_load_read", 32'(rdat_img), 32'd0);

        // width=0, height=70 -> 1x60 frame
        do_start(0, 70);
        for (int i = 0; i < 60; i++) begin
            wr_valid = 1'b1; wr_data = 8'($urandom); step();
            if (i == 58) check_eq("tall_fr_59", 32'(frame_ready), 32'd0);
        end
        wr_valid = 1'b0;
        check_eq("tall_fr_60", 32'(frame_ready), 32'd1);
        for (int i = 0; i < 16; i++) do_read($urandom_range(0, 3), $urandom_range(0, 70));

        // Random frames with gaps, interleaved reads and occasional restarts
        for (int f = 0; f < 3; f++) begin
            int cyc;
            do_start($urandom_range(0, 70), $urandom_range(0, 8));
            cyc = 0;
            while (!m_ready && cyc < 3000) begin
                start_load = 1'($urandom_range(0, 150) == 0);
                img_width  = 7'($urandom_range(1, 20));
                img_height = 7'($urandom_range(1, 4));
                wr_valid   = 1'($urandom_range(0, 3) != 0);
                wr_data    = 8'($urandom);
                ren_img    = 1'($urandom);
                x_addr_img = 7'($urandom_range(0, 63));
                y_addr_img = 7'($urandom_range(0, 9));
                step();
                cyc++;
            end
            start_load = 1'b0; wr_valid = 1'b0;
            check_eq("rand_frame_done", 32'(frame_ready), 32'd1);
            for (int i = 0; i < 30; i++) begin
                ren_img    = 1'($urandom_range(0, 4) != 0);
                x_addr_img = 7'($urandom_range(0, 70));
                y_addr_img = 7'($urandom_range(0, 10));
                step();
            end
            ren_img = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
